msg_schedule: RTL and testbench
===============================

Name: msg_schedule

Overview:
- Downstream neighbour of the padding stage. Accepts one padded 512-bit message block and expands it into the 64-word SHA-256 message schedule W0..W63.
- Emits one 32-bit word per accepted handshake to the compression-round stage.
- Uses a 16-word rolling window, one new word per cycle. No 64-entry array is stored.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block. Legal range 16..64. Production value is 64.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- blk_valid  in  1  padded block available; driven from padder's padded_i
- blk_in  in  512  padded block; bits [511:480] = W0, big-endian word order
- blk_ready  out  1  schedule can accept a new block
- w_valid  out  1  w_out/w_idx hold a valid schedule word
- w_ready  in  1  round stage consumes the word this cycle
- w_out  out  32  current schedule word W_t
- w_idx  out  6  index t of w_out
- sched_done  out  1  one-cycle pulse when word ROUNDS-1 is accepted

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, blk_ready=1, w_valid=0, w_out=0, w_idx=0, sched_done=0, window cleared.
- States:
  - IDLE: blk_ready=1, w_valid=0. On blk_valid&&blk_ready, load win[i] = blk_in[511-32i -: 32] for i=0..15, set t=0, go to RUN.
  - RUN: blk_ready=0, w_valid=1, w_out=win[0], w_idx=t.
- Word advance, on w_valid&&w_ready:
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], all mod 2^32.
  - t <= t+1.
- Sigma functions: σ0(x)=ROTR7^ROTR18^SHR3; σ1(x)=ROTR17^ROTR19^SHR10.
- Last word: when t==ROUNDS-1 is accepted, pulse sched_done that same cycle (registered, visible the next cycle). Return to IDLE; blk_ready=1 the following cycle.
- Latency: block accepted at edge N → W0 valid from the cycle after N. With w_ready held high, W_t appears at cycle N+1+t. Block-to-block throughput is ROUNDS+1 cycles.
- Stall: w_ready=0 holds w_out, w_idx and the window unchanged. w_valid stays 1 (no retraction).
- Words t≥48 compute unused win[15] values. These are harmless and must not be gated.
- blk_valid while in RUN is ignored. blk_in is sampled only on the IDLE handshake; the padder must hold its block until then.
- Reset mid-RUN: back to IDLE next cycle, w_valid=0, no sched_done pulse. The partial schedule is discarded.
- blk_valid asserted during the reset cycle is not captured.
- w_idx does not wrap within a block; the maximum emitted value is ROUNDS-1.
- Arithmetic: 32-bit unsigned, carries beyond bit 31 dropped. No saturation.

Decomposition:
- Shared package sha256_pkg:
  - word_t (logic [31:0])
  - constants SHA_BLK_W=512, SHA_WORD_W=32, SHA_ROUNDS=64
  - functions small_sigma0, small_sigma1, reused by the round stage
- Sub-module sha256_w_next: purely combinational. Inputs are the four window words (w0, w1, w9, w14); output is the next word.
- The FSM, counter and window stay in msg_schedule.

Test Plan:
1. "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 → W0..W15 echo the input words. W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6. All 64 words match the golden model. sched_done pulses after the 64th word.
2. Backpressure: same block, w_ready toggled pseudo-randomly → identical word sequence. w_out/w_idx stable during every w_ready=0 cycle. w_valid never drops mid-block.
3. Back-to-back: two blocks (the "abc" block, then an all-0xFF block) with blk_valid held → second block accepted exactly one cycle after sched_done. blk_ready=0 throughout RUN. Second sequence matches the golden model.
4. Reset at t=30 → next cycle w_valid=0, blk_ready=1, no sched_done. A new block then restarts at w_idx=0.
5. ROUNDS=16 build → only W0..W15 emitted, equal to the input words. sched_done after w_idx=15.
6. Ignored input: blk_valid pulsed with a different blk_in while in RUN → no change to the emitted sequence.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and small-sigma helpers.
// Used by the message schedule and the compression-round stage.
package sha256_pkg;

    localparam int unsigned SHA_BLK_W  = 512;
    localparam int unsigned SHA_WORD_W = 32;
    localparam int unsigned SHA_ROUNDS = 64;

    typedef logic [SHA_WORD_W-1:0] word_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } sched_state_t;

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word from the rolling window:
// W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16, modulo 2^32.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w9,
    input  logic [31:0] w14,
    output logic [31:0] w_next
);

    assign w_next = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into ROUNDS words,
// one word per handshake, using a 16-word rolling window.
module msg_schedule #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic [511:0] blk_in,
    output logic         blk_ready,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         sched_done
);
    import sha256_pkg::*;

    sched_state_t state, state_next;
    word_t        win [16];
    word_t        w_new;
    logic [5:0]   t;
    logic         fire;
    logic         last;

    assign fire  = w_valid && w_ready;
    assign last  = (t == 6'(ROUNDS - 1));
    assign w_out = win[0];
    assign w_idx = t;

    sha256_w_next u_w_next (
        .w0     (win[0]),
        .w1     (win[1]),
        .w9     (win[9]),
        .w14    (win[14]),
        .w_next (w_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        blk_ready  = 1'b0;
        w_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_valid = 1'b1;
                if (fire && last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Window and index advance only on a load or an accepted word; a stall holds both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            t          <= '0;
            sched_done <= 1'b0;
        end else begin
            sched_done <= fire && last;
            if (state == S_IDLE && blk_valid) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    win[i] <= blk_in[SHA_BLK_W - 1 - SHA_WORD_W * i -: SHA_WORD_W];
                end
                t <= '0;
            end else if (fire) begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win[i] <= win[i + 1];
                end
                win[15] <= w_new;
                t       <= last ? 6'd0 : t + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: a 64-round and a 16-round instance share
// stimulus; expected words come from a full-array SHA-256 schedule model.
module tb_msg_schedule;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_in = '0;
    logic         w_ready = 1'b0;
    logic         blk_ready  [2];
    logic         w_valid    [2];
    logic         sched_done [2];
    logic [31:0]  w_out      [2];
    logic [5:0]   w_idx      [2];

    bit           bp = 1'b0;
    exp_t         exp_q [2][$];
    bit           active [2];
    bit           done_pend [2];
    bit           rst_q = 1'b1;
    exp_t         e;
    logic [31:0]  ws [64];
    int           errors = 0;
    int           checks = 0;
    int           tmo_req = 0;
    int           tmo_seen = 0;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_in(blk_in),
        .blk_ready(blk_ready[0]), .w_valid(w_valid[0]), .w_ready(w_ready),
        .w_out(w_out[0]), .w_idx(w_idx[0]), .sched_done(sched_done[0])
    );

    msg_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_in(blk_in),
        .blk_ready(blk_ready[1]), .w_valid(w_valid[1]), .w_ready(w_ready),
        .w_out(w_out[1]), .w_idx(w_idx[1]), .sched_done(sched_done[1])
    );

    initial forever #5 clk = ~clk;

    function automatic int rounds(input int g);
        return (g == 0) ? 64 : 16;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule: full 64-entry array indexed by t.
    function automatic void schedule(input logic [511:0] b, output logic [31:0] w [64]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = b[511 - 32 * t -: 32];
            end else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32 * i +: 32] = $urandom;
        end
        return b;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, g, act, expv);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (tmo_req != tmo_seen) begin
            checks++;
            errors++;
            tmo_seen++;
        end
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                exp_q[g].delete();
                active[g]    = 1'b0;
                done_pend[g] = 1'b0;
            end else begin
                if (rst_q) begin
                    chk("reset_w_out", g, w_out[g], 32'h0);
                    chk("reset_w_idx", g, 32'(w_idx[g]), 32'h0);
                end
                chk("sched_done", g, 32'(sched_done[g]), 32'(done_pend[g]));
                done_pend[g] = 1'b0;
                chk("w_valid", g, 32'(w_valid[g]), 32'(active[g]));
                chk("blk_ready", g, 32'(blk_ready[g]), 32'(!active[g]));
                if (w_valid[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word dut%0d: got idx %0d word %h expected none",
                                 g, w_idx[g], w_out[g]);
                    end else begin
                        e = exp_q[g][0];
                        chk("w_idx", g, 32'(w_idx[g]), 32'(e.idx));
                        chk("w_out", g, w_out[g], e.w);
                        if (w_ready) begin
                            void'(exp_q[g].pop_front());
                            if (int'(e.idx) == rounds(g) - 1) begin
                                done_pend[g] = 1'b1;
                                active[g]    = 1'b0;
                            end
                        end
                    end
                end
                if (blk_valid && blk_ready[g]) begin
                    schedule(blk_in, ws);
                    for (int t = 0; t < rounds(g); t++) begin
                        e.idx = 6'(t);
                        e.w   = ws[t];
                        exp_q[g].push_back(e);
                    end
                    active[g] = 1'b1;
                end
            end
        end
        rst_q = rst;
    end

    initial forever begin
        @(posedge clk);
        #1;
        w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic [511:0] b, input bit hold);
        bit ok;
        ok = 1'b0;
        blk_in    = b;
        blk_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = blk_ready[0] && !rst;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            $display("FAIL send_timeout: got no blk_ready expected accept within 300 cycles");
            tmo_req++;
        end
        if (!hold) blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = blk_ready[0] && blk_ready[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        if (!ok) begin
            $display("FAIL idle_timeout: got pending words expected idle within 500 cycles");
            tmo_req++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // "abc" block, w_ready held high
        send(ABC_BLK, 1'b0);
        wait_idle();

        // same block under random backpressure
        bp = 1'b1;
        send(ABC_BLK, 1'b0);
        wait_idle();
        bp = 1'b0;

        // back-to-back with blk_valid held
        send(ABC_BLK, 1'b1);
        send('1, 1'b0);
        wait_idle();

        // reset in the middle of a block, then restart
        send(rand_blk(), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = w_valid[0] && w_idx[0] == 6'd30;
        end
        if (!seen) begin
            $display("FAIL reach_idx30: got no w_idx 30 expected within 200 cycles");
            tmo_req++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(rand_blk(), 1'b0);
        wait_idle();

        // blk_valid with a different block while running is ignored
        send(rand_blk(), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        blk_in    = rand_blk();
        blk_valid = 1'b1;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        wait_idle();

        // random blocks, random backpressure
        bp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(rand_blk(), 1'b0);
            wait_idle();
        end
        bp = 1'b0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
